// File: rtl/utils_pkg.sv
// Shared definitions for the RV64I core datapath.
//   DATA_WIDTH / STRB_WIDTH : datapath width and byte-strobe count
//   lsu_state_e             : load/store unit FSM states
//   F3_*                    : RISC-V load/store funct3 encodings
//   sext_* / zext_*         : sign / zero extension to DATA_WIDTH
//   size_mask               : byte-strobe base pattern for an access size
//   lsu_misaligned          : natural-alignment check for an access size
package utils_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MREQ  = 2'd1,
    ST_MWAIT = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  function automatic logic [DATA_WIDTH-1:0] sext_8(input logic [7:0] v);
    return {{(DATA_WIDTH-8){v[7]}}, v};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sext_16(input logic [15:0] v);
    return {{(DATA_WIDTH-16){v[15]}}, v};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sext_32(input logic [31:0] v);
    return {{(DATA_WIDTH-32){v[31]}}, v};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] zext_8(input logic [7:0] v);
    return {{(DATA_WIDTH-8){1'b0}}, v};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] zext_16(input logic [15:0] v);
    return {{(DATA_WIDTH-16){1'b0}}, v};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] zext_32(input logic [31:0] v);
    return {{(DATA_WIDTH-32){1'b0}}, v};
  endfunction

  // funct3[1:0] encodes the access size for both loads and stores.
  function automatic logic [STRB_WIDTH-1:0] size_mask(input logic [2:0] funct3);
    logic [STRB_WIDTH-1:0] m;
    case (funct3[1:0])
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] funct3,
                                          input logic [2:0] off);
    logic mis;
    case (funct3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = |off[1:0];
      2'b11:   mis = |off;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: shifts the addressed bytes of an aligned doubleword
// down to bit 0 and sign/zero-extends them according to funct3.
//   mem_rdata : aligned 64-bit doubleword from memory
//   byte_off  : address bits [2:0] of the load
//   funct3    : RISC-V load funct3
//   load_data : extended result (0 for the unused 111 encoding)
module lsu_load_align
  import utils_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [2:0]            byte_off,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] load_data
);

  logic [DATA_WIDTH-1:0] shifted;

  always_comb begin
    shifted   = mem_rdata >> {byte_off, 3'b000};
    load_data = '0;
    case (funct3)
      F3_B:    load_data = sext_8(shifted[7:0]);
      F3_H:    load_data = sext_16(shifted[15:0]);
      F3_W:    load_data = sext_32(shifted[31:0]);
      F3_D:    load_data = shifted;
      F3_BU:   load_data = zext_8(shifted[7:0]);
      F3_HU:   load_data = zext_16(shifted[15:0]);
      F3_WU:   load_data = zext_32(shifted[31:0]);
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store unit memory stage of the RV64I core. One op in flight at a time.
//   req_*      : op from execute (valid/ready)
//   mem_req_*  : doubleword-aligned memory request (valid/ready)
//   mem_rsp_*  : memory response, single-cycle pulse, only honoured in MWAIT
//   rsp_*      : result to writeback (valid/ready)
//   dbg_state  : current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. Once a valid is raised it stays high and its payload stays stable
// until that transfer; ready may be dropped at any time.
module lsu_mem_stage
  import utils_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [STRB_WIDTH-1:0] mem_wstrb,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [4:0]            rsp_rd,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_misaligned,
  output logic                  rsp_illegal,
  output logic [1:0]            dbg_state
);

  lsu_state_e            state_q, state_d;
  logic                  is_store_q, is_store_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [4:0]            rd_q, rd_d;
  logic                  mis_q, mis_d;
  logic                  ill_q, ill_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [DATA_WIDTH-1:0] load_data;
  logic                  new_ill;
  logic                  new_mis;

  lsu_load_align u_load_align (
    .mem_rdata (mem_rdata),
    .byte_off  (addr_q[2:0]),
    .funct3    (funct3_q),
    .load_data (load_data)
  );

  // Illegal wins over misaligned, so misaligned is only flagged for legal ops.
  always_comb begin
    new_ill = req_is_store ? req_funct3[2] : (req_funct3 == 3'b111);
    new_mis = !new_ill && lsu_misaligned(req_funct3, req_addr[2:0]);
  end

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    mis_d      = mis_q;
    ill_d      = ill_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          is_store_d = req_is_store;
          funct3_d   = req_funct3;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          rd_d       = req_rd;
          ill_d      = new_ill;
          mis_d      = new_mis;
          rsp_data_d = '0;
          state_d    = (new_ill || new_mis) ? ST_RESP : ST_MREQ;
        end
      end
      ST_MREQ: begin
        if (mem_req_ready) state_d = ST_MWAIT;
      end
      ST_MWAIT: begin
        if (mem_rsp_valid) begin
          if (!is_store_q) rsp_data_d = load_data;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      mis_q      <= 1'b0;
      ill_q      <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      mis_q      <= mis_d;
      ill_q      <= ill_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Outputs decode straight from registered state and latched fields, and are
  // held at 0 outside the state that owns them.
  logic in_mreq;
  logic in_resp;
  logic st_req;

  always_comb begin
    in_mreq        = (state_q == ST_MREQ);
    in_resp        = (state_q == ST_RESP);
    st_req         = in_mreq && is_store_q;
    req_ready      = (state_q == ST_IDLE);
    mem_req_valid  = in_mreq;
    mem_we         = st_req;
    mem_addr       = in_mreq ? {addr_q[DATA_WIDTH-1:3], 3'b000} : '0;
    mem_wdata      = st_req ? (wdata_q << {addr_q[2:0], 3'b000}) : '0;
    mem_wstrb      = st_req ? (size_mask(funct3_q) << addr_q[2:0]) : '0;
    rsp_valid      = in_resp;
    rsp_rd         = (in_resp && !is_store_q) ? rd_q : 5'd0;
    rsp_data       = in_resp ? rsp_data_q : '0;
    rsp_misaligned = in_resp && mis_q;
    rsp_illegal    = in_resp && ill_q;
    dbg_state      = state_q;
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;
  logic        rsp_valid, rsp_ready;
  logic [4:0]  rsp_rd;
  logic [63:0] rsp_data;
  logic        rsp_misaligned, rsp_illegal;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int accept_cyc = 0;

  lsu_mem_stage dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
    .rsp_data(rsp_data), .rsp_misaligned(rsp_misaligned),
    .rsp_illegal(rsp_illegal), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver: present an op and hold it until accepted; returns in the cycle after acceptance
  task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input logic [4:0] rd);
    int n = 0;
    req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin tick(); n++; end
    if (!req_ready) check("issue_timeout", 64'd0, 64'd1);
    accept_cyc = cyc;
    tick();
    req_valid = 1'b0;
  endtask

  // driver: memory side; stalls mem_req_ready, then acks and returns rdata
  task automatic mem_serve(input string tag, input int stall, input logic [63:0] rdata,
                           input logic [63:0] e_addr, input logic [63:0] e_wdata,
                           input logic [7:0] e_strb, input logic e_we);
    int n = 0;
    while (!mem_req_valid && n < 50) begin tick(); n++; end
    check({tag, "_mvalid"}, mem_req_valid, 1'b1);
    check({tag, "_maddr"},  mem_addr, e_addr);
    check({tag, "_mwe"},    mem_we, e_we);
    check({tag, "_mwstrb"}, mem_wstrb, e_strb);
    check({tag, "_mwdata"}, mem_wdata, e_wdata);
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, "_stall_mvalid"}, mem_req_valid, 1'b1);
      check({tag, "_stall_maddr"},  mem_addr, e_addr);
      check({tag, "_stall_rready"}, req_ready, 1'b0);
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check({tag, "_mvalid_drop"}, mem_req_valid, 1'b0);
    mem_rsp_valid = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rdata = '0;
  endtask

  // driver: writeback side; checks the result, stalls rsp_ready, then completes
  task automatic rsp_take(input string tag, input int stall, input logic [4:0] e_rd,
                          input logic [63:0] e_data, input logic e_mis, input logic e_ill);
    int n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    check({tag, "_rvalid"}, rsp_valid, 1'b1);
    check({tag, "_rd"},     rsp_rd, e_rd);
    check({tag, "_data"},   rsp_data, e_data);
    check({tag, "_mis"},    rsp_misaligned, e_mis);
    check({tag, "_ill"},    rsp_illegal, e_ill);
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, "_stall_rvalid"}, rsp_valid, 1'b1);
      check({tag, "_stall_data"},   rsp_data, e_data);
      check({tag, "_stall_rd"},     rsp_rd, e_rd);
      check({tag, "_stall_rready"}, req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_done_rvalid"}, rsp_valid, 1'b0);
    check({tag, "_done_ready"},  req_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 0; req_is_store = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0; rsp_ready = 0;
    tick(); tick();
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_mvalid",    mem_req_valid, 1'b0);
    check("rst_rvalid",    rsp_valid, 1'b0);
    rst = 1'b0;
    tick();
    check("idle_req_ready", req_ready, 1'b1);
    check("idle_mwstrb",    mem_wstrb, 8'h00);
    check("idle_maddr",     mem_addr, 64'd0);
    check("idle_rdata",     rsp_data, 64'd0);

    // LB at 0x1003, lane 3 = 0x80; latency check
    issue(1'b0, 3'b000, 64'h1003, 64'd0, 5'd5);
    mem_serve("lb", 0, 64'h0000_0000_80FF_0000, 64'h1000, 64'd0, 8'h00, 1'b0);
    check("lb_latency", cyc - accept_cyc, 3);
    rsp_take("lb", 0, 5'd5, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b0);

    // LBU same address
    issue(1'b0, 3'b100, 64'h1003, 64'd0, 5'd6);
    mem_serve("lbu", 0, 64'h0000_0000_80FF_0000, 64'h1000, 64'd0, 8'h00, 1'b0);
    rsp_take("lbu", 0, 5'd6, 64'h0000_0000_0000_0080, 1'b0, 1'b0);

    // SH at 0x2006: lane 6..7, upper bits of wdata shifted out
    issue(1'b1, 3'b001, 64'h2006, 64'h1234_ABCD, 5'd7);
    mem_serve("sh", 0, 64'd0, 64'h2000, 64'hABCD_0000_0000_0000, 8'hC0, 1'b1);
    rsp_take("sh", 0, 5'd0, 64'd0, 1'b0, 1'b0);

    // LW misaligned: no memory access, response next cycle
    issue(1'b0, 3'b010, 64'h3002, 64'd0, 5'd9);
    check("lw_mis_latency", cyc - accept_cyc, 1);
    check("lw_mis_mvalid", mem_req_valid, 1'b0);
    rsp_take("lw_mis", 0, 5'd9, 64'd0, 1'b1, 1'b0);

    // Load funct3=111 at odd address: illegal wins over misaligned
    issue(1'b0, 3'b111, 64'h3001, 64'd0, 5'd11);
    check("ld_ill_mvalid", mem_req_valid, 1'b0);
    rsp_take("ld_ill", 0, 5'd11, 64'd0, 1'b0, 1'b1);

    // Store funct3=100 illegal
    issue(1'b1, 3'b100, 64'h3000, 64'h55, 5'd12);
    check("st_ill_mvalid", mem_req_valid, 1'b0);
    rsp_take("st_ill", 0, 5'd0, 64'd0, 1'b0, 1'b1);

    // SW misaligned store
    issue(1'b1, 3'b010, 64'h3006, 64'h55, 5'd1);
    rsp_take("sw_mis", 0, 5'd0, 64'd0, 1'b1, 1'b0);

    // LD with back-pressure on both ports
    issue(1'b0, 3'b011, 64'h5008, 64'd0, 5'd3);
    mem_serve("ld_bp", 5, 64'h0123_4567_89AB_CDEF, 64'h5008, 64'd0, 8'h00, 1'b0);
    rsp_take("ld_bp", 3, 5'd3, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);

    // Reset during MWAIT, then stray memory response
    issue(1'b0, 3'b011, 64'h7000, 64'd0, 5'd4);
    check("rstmid_mvalid", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rstmid_mvalid0", mem_req_valid, 1'b0);
    check("rstmid_rvalid0", rsp_valid, 1'b0);
    check("rstmid_ready",   req_ready, 1'b1);
    check("rstmid_maddr",   mem_addr, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    mem_rsp_valid = 1'b1;
    mem_rdata = '1;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rdata = '0;
    tick();
    check("stray_rvalid", rsp_valid, 1'b0);
    check("stray_ready",  req_ready, 1'b1);
    check("stray_data",   rsp_data, 64'd0);
    check("stray_mvalid", mem_req_valid, 1'b0);
    issue(1'b0, 3'b001, 64'h6002, 64'd0, 5'd13);
    mem_serve("lh", 0, 64'h0000_0000_8001_0000, 64'h6000, 64'd0, 8'h00, 1'b0);
    rsp_take("lh", 0, 5'd13, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 1'b0);

    // Back-to-back LWU then SD, req_valid held during the RESP handshake
    issue(1'b0, 3'b110, 64'h4004, 64'd0, 5'd10);
    begin
      int t0;
      t0 = accept_cyc;
      mem_serve("lwu", 0, 64'hDEAD_BEEF_0000_0000, 64'h4000, 64'd0, 8'h00, 1'b0);
      check("lwu_rvalid", rsp_valid, 1'b1);
      check("lwu_data",   rsp_data, 64'h0000_0000_DEAD_BEEF);
      check("lwu_rd",     rsp_rd, 5'd10);
      check("lwu_ready0", req_ready, 1'b0);
      rsp_ready = 1'b1;
      req_is_store = 1'b1; req_funct3 = 3'b011; req_addr = 64'h4008;
      req_wdata = 64'h1122_3344_5566_7788; req_rd = 5'd2;
      req_valid = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("b2b_not_early", mem_req_valid, 1'b0);
      check("b2b_ready",     req_ready, 1'b1);
      check("b2b_spacing",   cyc - t0, 4);
      tick();
      req_valid = 1'b0;
    end
    mem_serve("sd", 0, 64'd0, 64'h4008, 64'h1122_3344_5566_7788, 8'hFF, 1'b1);
    rsp_take("sd", 0, 5'd0, 64'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
